// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit slice.
//   - state_t    : FSM state encoding
//   - opcode_t   : instruction opcode field values (IR[7:6])
//   - REG_A/REG_G: bus bit indices of the accumulator input and ALU result registers
//   - reg_sel_t  : enable + 4-bit register index fed to reg_select_decoder
package control_unit_pkg;

  localparam int BUS_W = 16;

  localparam logic [3:0] REG_A = 4'd8;
  localparam logic [3:0] REG_G = 4'd9;

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_T1    = 3'd3,
    ST_T2    = 3'd4,
    ST_T3    = 3'd5,
    ST_WAIT  = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OP_MOV  = 2'b00,
    OP_WAIT = 2'b01,
    OP_ADD  = 2'b10,
    OP_XOR  = 2'b11
  } opcode_t;

  typedef struct packed {
    logic       en;
    logic [3:0] idx;
  } reg_sel_t;

  // Select a register on the bus: general registers r0-r7 or REG_A/REG_G.
  function automatic reg_sel_t sel(input logic [3:0] idx);
    return '{en: 1'b1, idx: idx};
  endfunction

  // Widen a 3-bit general-register field to a bus index.
  function automatic logic [3:0] gpr(input logic [2:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/control_unit_reg_select_decoder.sv
// reg_select_decoder: maps a 4-bit register index to a 16-bit one-hot bus value.
// Ports:
//   en     - when low the output is all zeros
//   idx    - register index (0-7 = r0-r7, 8 = A, 9 = G)
//   onehot - one-hot select; indices above 9 produce zero so bits 15:10 never assert
module reg_select_decoder
  import control_unit_pkg::*;
(
  input  logic             en,
  input  logic [3:0]       idx,
  output logic [BUS_W-1:0] onehot
);

  always_comb begin
    // NOTE: default assignment first so every path drives onehot and no latch is inferred.
    onehot = '0;
    if (en && (idx <= REG_G)) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle sequencer for a small bus-based datapath.
// Fetches an 8-bit instruction (opcode IR[7:6], rx IR[5:3], ry IR[2:0]) and
// steps the bus through MOV, ADD, XOR or WAIT.
// Ports:
//   clock       - system clock, rising edge
//   resetnot    - synchronous active-low reset
//   instruction - instruction word from instruction memory, captured in LATCH
//   go          - resume request, only honoured in WAIT
//   rout        - one-hot bus driver select (r0-r7, A=8, G=9)
//   ren         - one-hot register load enable, same map as rout
//   addxor      - ALU op (0 add, 1 xor), only meaningful in T2
//   increment   - program counter advance strobe (FETCH)
//   waiting     - high while stalled on WAIT
module control_unit
  import control_unit_pkg::*;
(
  input  logic             clock,
  input  logic             resetnot,
  input  logic [7:0]       instruction,
  input  logic             go,
  output logic [BUS_W-1:0] rout,
  output logic [BUS_W-1:0] ren,
  output logic             addxor,
  output logic             increment,
  output logic             waiting
);

  state_t     state, state_next;
  logic [7:0] ir;
  opcode_t    opcode;
  logic [2:0] rx, ry;
  reg_sel_t   rout_sel, ren_sel;

  assign opcode = opcode_t'(ir[7:6]);
  assign rx     = ir[5:3];
  assign ry     = ir[2:0];

  // State register.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!resetnot) state <= ST_RST;
    else           state <= state_next;
  end

  // Instruction register: loaded only at the end of LATCH, so instruction
  // changes at any other time cannot disturb the executing instruction.
  always_ff @(posedge clock) begin
    if (!resetnot)               ir <= '0;
    else if (state == ST_LATCH) ir <= instruction;
  end

  // Next-state logic. The WAIT branch is decided from the incoming word
  // because IR is only updated at the same edge.
  always_comb begin
    state_next = state;
    case (state)
      ST_RST:   state_next = ST_FETCH;
      ST_FETCH: state_next = ST_LATCH;
      ST_LATCH: state_next = (instruction[7:6] == OP_WAIT) ? ST_WAIT : ST_T1;
      ST_T1:    state_next = (opcode == OP_MOV) ? ST_FETCH : ST_T2;
      ST_T2:    state_next = ST_T3;
      ST_T3:    state_next = ST_FETCH;
      ST_WAIT:  state_next = go ? ST_FETCH : ST_WAIT;
      default:  state_next = ST_RST;
    endcase
  end

  // Output decode from state and IR only.
  always_comb begin
    rout_sel  = '0;
    ren_sel   = '0;
    addxor    = 1'b0;
    increment = 1'b0;
    waiting   = 1'b0;
    case (state)
      ST_FETCH: increment = 1'b1;
      ST_T1: begin
        if (opcode == OP_MOV) begin
          rout_sel = sel(gpr(ry));
          ren_sel  = sel(gpr(rx));
        end else begin
          rout_sel = sel(gpr(rx));
          ren_sel  = sel(REG_A);
        end
      end
      ST_T2: begin
        rout_sel = sel(gpr(ry));
        ren_sel  = sel(REG_G);
        addxor   = ir[6];  // 0 for ADD (10), 1 for XOR (11)
      end
      ST_T3: begin
        rout_sel = sel(REG_G);
        ren_sel  = sel(gpr(rx));
      end
      ST_WAIT: waiting = 1'b1;
      default: ;
    endcase
  end

  reg_select_decoder u_rout_dec (
    .en     (rout_sel.en),
    .idx    (rout_sel.idx),
    .onehot (rout)
  );

  reg_select_decoder u_ren_dec (
    .en     (ren_sel.en),
    .idx    (ren_sel.idx),
    .onehot (ren)
  );

endmodule
